// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported asynchronous SRAM.
// Each access runs IDLE -> SETUP -> ACCESS (WAIT_CYCLES) -> DONE.
module sram_arbiter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_done,
  input  logic        ldr_req,
  input  logic        ldr_we,
  input  logic [15:0] ldr_addr,
  input  logic [15:0] ldr_wdata,
  output logic [15:0] ldr_rdata,
  output logic        ldr_done,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        Mem_OE,
  output logic        Mem_WE,
  output logic [1:0]  grant
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_CPU  = 2'b01;
  localparam logic [1:0] GNT_LDR  = 2'b10;

  state_t      state_r;
  state_t      state_next_s;
  logic [3:0]  cnt_r;
  logic [3:0]  cnt_next_s;
  logic [1:0]  grant_next_s;
  logic        last_ldr_r;
  logic        pick_ldr_s;
  logic        take_s;
  logic        capture_s;
  logic        we_r;
  logic        oe_next_s;
  logic        wen_next_s;
  logic        cpu_done_next_s;
  logic        ldr_done_next_s;

  // Round-robin pick: on a tie the port that was not served last wins
  always_comb begin
    pick_ldr_s = 1'b0;
    if (cpu_req && ldr_req) begin
      pick_ldr_s = ~last_ldr_r;
    end else if (ldr_req) begin
      pick_ldr_s = 1'b1;
    end else begin
      pick_ldr_s = 1'b0;
    end
  end

  // Next-state logic; strobes are computed one cycle early so they leave the block registered
  always_comb begin
    state_next_s    = state_r;
    cnt_next_s      = cnt_r;
    grant_next_s    = grant;
    take_s          = 1'b0;
    capture_s       = 1'b0;
    oe_next_s       = 1'b0;
    wen_next_s      = 1'b0;
    cpu_done_next_s = 1'b0;
    ldr_done_next_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (cpu_req || ldr_req) begin
          take_s       = 1'b1;
          state_next_s = SETUP;
          grant_next_s = pick_ldr_s ? GNT_LDR : GNT_CPU;
        end else begin
          state_next_s = IDLE;
          grant_next_s = GNT_NONE;
        end
      end
      SETUP: begin
        state_next_s = ACCESS;
        cnt_next_s   = CNT_LOAD;
        oe_next_s    = ~we_r;
        wen_next_s   = we_r;
      end
      ACCESS: begin
        if (cnt_r == 4'd0) begin
          state_next_s    = DONE;
          capture_s       = ~we_r;
          cpu_done_next_s = (grant == GNT_CPU);
          ldr_done_next_s = (grant == GNT_LDR);
        end else begin
          cnt_next_s = cnt_r - 4'd1;
          oe_next_s  = ~we_r;
          wen_next_s = we_r;
        end
      end
      DONE: begin
        state_next_s = IDLE;
        grant_next_s = GNT_NONE;
      end
      default: begin
        state_next_s = IDLE;
        grant_next_s = GNT_NONE;
      end
    endcase
  end

  // State, counter, grant and SRAM strobe registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r  <= IDLE;
      cnt_r    <= 4'd0;
      grant    <= GNT_NONE;
      Mem_OE   <= 1'b0;
      Mem_WE   <= 1'b0;
      cpu_done <= 1'b0;
      ldr_done <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      cnt_r    <= cnt_next_s;
      grant    <= grant_next_s;
      Mem_OE   <= oe_next_s;
      Mem_WE   <= wen_next_s;
      cpu_done <= cpu_done_next_s;
      ldr_done <= ldr_done_next_s;
    end
  end

  // Winner's request is latched only at grant so later input changes cannot disturb the access
  always_ff @(posedge Clk) begin
    if (Reset) begin
      we_r       <= 1'b0;
      mem_addr   <= 16'h0000;
      mem_wdata  <= 16'h0000;
      last_ldr_r <= 1'b1;
    end else if (take_s) begin
      we_r       <= pick_ldr_s ? ldr_we    : cpu_we;
      mem_addr   <= pick_ldr_s ? ldr_addr  : cpu_addr;
      mem_wdata  <= pick_ldr_s ? ldr_wdata : cpu_wdata;
      last_ldr_r <= pick_ldr_s;
    end
  end

  // Read data lands only in the granted port's register, on the last ACCESS edge
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cpu_rdata <= 16'h0000;
      ldr_rdata <= 16'h0000;
    end else if (capture_s) begin
      if (grant == GNT_LDR) begin
        ldr_rdata <= mem_rdata;
      end else begin
        cpu_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed vector table, hand-written corner
// sequences, and a random run against a transaction-level reference model.
module tb_sram_arbiter;

  localparam int W = 2;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        cpu_req, cpu_we, ldr_req, ldr_we;
  logic [15:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;
  logic [15:0] cpu_rdata, ldr_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_done, ldr_done, Mem_OE, Mem_WE;
  logic [1:0]  grant;

  logic [15:0] w_rdata = 16'h00C3;
  logic [15:0] a_cpu_rdata, a_ldr_rdata, a_mem_addr, a_mem_wdata;
  logic        a_cpu_done, a_ldr_done, a_oe, a_we;
  logic [1:0]  a_grant;
  logic [15:0] b_cpu_rdata, b_ldr_rdata, b_mem_addr, b_mem_wdata;
  logic        b_cpu_done, b_ldr_done, b_oe, b_we;
  logic [1:0]  b_grant;

  logic [15:0] sram [0:65535];
  logic        pre_we = 1'b0;
  logic [15:0] pre_addr = 16'h0000, pre_data = 16'h0000;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  sram_arbiter #(.WAIT_CYCLES(W)) dut (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_rdata(ldr_rdata), .ldr_done(ldr_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .grant(grant));

  sram_arbiter #(.WAIT_CYCLES(1)) dut_w1 (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(a_cpu_rdata), .cpu_done(a_cpu_done),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_rdata(a_ldr_rdata), .ldr_done(a_ldr_done),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(w_rdata),
    .Mem_OE(a_oe), .Mem_WE(a_we), .grant(a_grant));

  sram_arbiter #(.WAIT_CYCLES(15)) dut_w15 (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(b_cpu_rdata), .cpu_done(b_cpu_done),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_rdata(b_ldr_rdata), .ldr_done(b_ldr_done),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(w_rdata),
    .Mem_OE(b_oe), .Mem_WE(b_we), .grant(b_grant));

  // Behavioural asynchronous SRAM behind the main instance, plus a bench preload port
  assign mem_rdata = sram[mem_addr];
  always @(posedge Clk) begin
    if (Mem_WE) sram[mem_addr] <= mem_wdata;
    else if (pre_we) sram[pre_addr] <= pre_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1; cpu_req = 1'b0; ldr_req = 1'b0;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Reset = 1'b0;
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    pre_addr = a; pre_data = d; pre_we = 1'b1;
    @(posedge Clk); #1;
    pre_we = 1'b0;
  endtask

  // Results of run_one
  int          r_lat, r_oe, r_we, r_both, r_my, r_other;
  logic [1:0]  r_gnt;
  logic [15:0] r_addr, r_wdata;

  task automatic run_one(input bit ldr, input bit we, input logic [15:0] a, input logic [15:0] d);
    bit my_d, ot_d;
    r_lat = -1; r_oe = 0; r_we = 0; r_both = 0; r_my = 0; r_other = 0;
    r_gnt = 2'b00; r_addr = 16'hxxxx; r_wdata = 16'hxxxx;
    if (ldr) begin ldr_req = 1'b1; ldr_we = we; ldr_addr = a; ldr_wdata = d; end
    else     begin cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
    for (int c = 1; c <= 30; c++) begin
      @(posedge Clk); #1;
      if (Mem_OE) r_oe++;
      if (Mem_WE) r_we++;
      if (Mem_OE && Mem_WE) r_both++;
      if (Mem_OE || Mem_WE) begin r_addr = mem_addr; r_wdata = mem_wdata; end
      if (grant != 2'b00) r_gnt = grant;
      my_d = ldr ? ldr_done : cpu_done;
      ot_d = ldr ? cpu_done : ldr_done;
      if (ot_d) r_other++;
      if (my_d) begin
        r_my++;
        if (r_lat < 0) begin
          r_lat = c;
          if (ldr) ldr_req = 1'b0; else cpu_req = 1'b0;
        end
      end
      if (r_lat >= 0 && c >= r_lat + 2) break;
    end
    if (ldr) ldr_req = 1'b0; else cpu_req = 1'b0;
  endtask

  // Both ports request together; records grant order and each port's done latency
  logic [1:0] t_first, t_second;
  int         t_cpu_lat, t_ldr_lat;
  task automatic serve_both();
    logic [1:0] prev;
    int n;
    prev = 2'b00; n = 0; t_first = 2'b00; t_second = 2'b00; t_cpu_lat = -1; t_ldr_lat = -1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0001;
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 16'h0002;
    for (int c = 1; c <= 60; c++) begin
      @(posedge Clk); #1;
      if (grant != 2'b00 && grant != prev) begin
        if (n == 0) t_first = grant; else if (n == 1) t_second = grant;
        n++;
      end
      prev = grant;
      if (cpu_done && t_cpu_lat < 0) begin t_cpu_lat = c; cpu_req = 1'b0; end
      if (ldr_done && t_ldr_lat < 0) begin t_ldr_lat = c; ldr_req = 1'b0; end
      if (!cpu_req && !ldr_req && grant == 2'b00) break;
    end
    cpu_req = 1'b0; ldr_req = 1'b0;
  endtask

  typedef struct {
    bit          ldr;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          lat;
    int          oe_n;
    int          we_n;
    logic [1:0]  gnt;
    logic [15:0] exp_cpu_rd;
    logic [15:0] exp_ldr_rd;
  } vec_t;

  vec_t vecs [6];

  // Transaction-level reference model state
  int          m_left;
  bit          m_ldr, m_last_ldr, m_we;
  logic [15:0] m_addr, m_wdata;
  logic [15:0] m_rd [2];
  logic [15:0] golden [16];

  task automatic model_reset();
    m_left = 0; m_ldr = 1'b0; m_last_ldr = 1'b1; m_we = 1'b0;
    m_addr = 16'h0000; m_wdata = 16'h0000; m_rd[0] = 16'h0000; m_rd[1] = 16'h0000;
  endtask

  task automatic model_step();
    if (m_left == 0) begin
      if (cpu_req || ldr_req) begin
        m_ldr = (cpu_req && ldr_req) ? !m_last_ldr : ldr_req;
        m_last_ldr = m_ldr;
        m_we    = m_ldr ? ldr_we    : cpu_we;
        m_addr  = m_ldr ? ldr_addr  : cpu_addr;
        m_wdata = m_ldr ? ldr_wdata : cpu_wdata;
        m_left  = W + 2;
      end
    end else begin
      if (m_left == 2) begin
        if (m_we) golden[m_addr[3:0]] = m_wdata;
        else m_rd[m_ldr] = golden[m_addr[3:0]];
      end
      m_left--;
    end
  endtask

  task automatic model_check();
    int ph;
    bit act;
    ph  = W + 2 - m_left;
    act = (m_left > 0) && (ph >= 1) && (ph <= W);
    chk("rnd grant", grant, (m_left > 0) ? (m_ldr ? 2'b10 : 2'b01) : 2'b00);
    chk("rnd cpu_done", cpu_done, (m_left == 1) && !m_ldr);
    chk("rnd ldr_done", ldr_done, (m_left == 1) && m_ldr);
    chk("rnd oe", Mem_OE, act && !m_we);
    chk("rnd we", Mem_WE, act && m_we);
    chk("rnd mem_addr", mem_addr, m_addr);
    chk("rnd mem_wdata", mem_wdata, m_wdata);
    chk("rnd cpu_rdata", cpu_rdata, m_rd[0]);
    chk("rnd ldr_rdata", ldr_rdata, m_rd[1]);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a_lat, b_lat, m_lat, a_oe_n, b_oe_n, m_oe_n, bad_misc;
    bit changed, seen;
    logic [15:0] d;

    vecs[0] = '{1'b0, 1'b0, 16'h0040, 16'h0000, 4, 2, 0, 2'b01, 16'hBEEF, 16'h0000};
    vecs[1] = '{1'b1, 1'b1, 16'h1234, 16'h5A5A, 4, 0, 2, 2'b10, 16'hBEEF, 16'h0000};
    vecs[2] = '{1'b1, 1'b0, 16'h1234, 16'h0000, 4, 2, 0, 2'b10, 16'hBEEF, 16'h5A5A};
    vecs[3] = '{1'b0, 1'b1, 16'h0040, 16'h1111, 4, 0, 2, 2'b01, 16'hBEEF, 16'h5A5A};
    vecs[4] = '{1'b0, 1'b0, 16'h0040, 16'h0000, 4, 2, 0, 2'b01, 16'h1111, 16'h5A5A};
    vecs[5] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 4, 2, 0, 2'b10, 16'h1111, 16'h1111};

    cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 16'h0000;
    ldr_we = 1'b0; ldr_addr = 16'h0000; ldr_wdata = 16'h0000;
    do_reset();
    chk("rst grant", grant, 2'b00);
    chk("rst oe", Mem_OE, 1'b0);
    chk("rst we", Mem_WE, 1'b0);
    chk("rst dones", {cpu_done, ldr_done}, 2'b00);
    chk("rst mem_addr", mem_addr, 16'h0000);
    chk("rst mem_wdata", mem_wdata, 16'h0000);
    chk("rst rdata", {cpu_rdata, ldr_rdata}, 32'h0);

    // Directed vector table
    preload(16'h0040, 16'hBEEF);
    for (int i = 0; i < 6; i++) begin
      run_one(vecs[i].ldr, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      chk($sformatf("v%0d lat", i), r_lat, vecs[i].lat);
      chk($sformatf("v%0d oe", i), r_oe, vecs[i].oe_n);
      chk($sformatf("v%0d we", i), r_we, vecs[i].we_n);
      chk($sformatf("v%0d both", i), r_both, 0);
      chk($sformatf("v%0d my_done", i), r_my, 1);
      chk($sformatf("v%0d other_done", i), r_other, 0);
      chk($sformatf("v%0d grant", i), r_gnt, vecs[i].gnt);
      chk($sformatf("v%0d addr", i), r_addr, vecs[i].addr);
      if (vecs[i].we) chk($sformatf("v%0d wdata", i), r_wdata, vecs[i].wdata);
      chk($sformatf("v%0d cpu_rdata", i), cpu_rdata, vecs[i].exp_cpu_rd);
      chk($sformatf("v%0d ldr_rdata", i), ldr_rdata, vecs[i].exp_ldr_rd);
    end

    // Tie after reset: CPU first, loader back-to-back, next tie CPU again
    do_reset();
    serve_both();
    chk("tie1 first", t_first, 2'b01);
    chk("tie1 second", t_second, 2'b10);
    chk("tie1 cpu lat", t_cpu_lat, 2 + W);
    chk("tie1 ldr lat", t_ldr_lat, (2 + W) + (3 + W));
    serve_both();
    chk("tie2 first", t_first, 2'b01);
    chk("tie2 second", t_second, 2'b10);

    // Reset during the second ACCESS cycle of a CPU write
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0077; cpu_wdata = 16'h4242;
    bad_misc = 0;
    for (int c = 1; c <= 3; c++) begin
      @(posedge Clk); #1;
      if (cpu_done) bad_misc++;
    end
    chk("rstmid we before", Mem_WE, 1'b1);
    Reset = 1'b1; cpu_req = 1'b0;
    @(posedge Clk); #1;
    Reset = 1'b0;
    chk("rstmid we", Mem_WE, 1'b0);
    chk("rstmid grant", grant, 2'b00);
    chk("rstmid mem_addr", mem_addr, 16'h0000);
    chk("rstmid rdata", {cpu_rdata, ldr_rdata}, 32'h0);
    for (int c = 1; c <= 3; c++) begin
      @(posedge Clk); #1;
      if (cpu_done || Mem_WE || grant != 2'b00) bad_misc++;
    end
    chk("rstmid no done", bad_misc, 0);
    run_one(1'b0, 1'b1, 16'h0077, 16'h4242);
    chk("rstmid retry lat", r_lat, 2 + W);
    chk("rstmid retry we", r_we, W);
    chk("rstmid retry wdata", r_wdata, 16'h4242);

    // Address change mid-access must not reach mem_addr
    preload(16'h0AAA, 16'h7E57);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0AAA;
    changed = 1'b0; seen = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge Clk); #1;
      if (Mem_OE && !changed) begin cpu_addr = 16'h0BBB; changed = 1'b1; end
      if (grant != 2'b00) chk("addrchg mem_addr", mem_addr, 16'h0AAA);
      if (cpu_done) begin
        seen = 1'b1; cpu_req = 1'b0;
        chk("addrchg rdata", cpu_rdata, 16'h7E57);
        break;
      end
    end
    chk("addrchg done seen", seen, 1'b1);
    @(posedge Clk); #1;
    chk("addrchg hold", mem_addr, 16'h0AAA);

    // WAIT_CYCLES sweep on the 1 / 2 / 15 instances sharing one request
    do_reset();
    a_lat = -1; b_lat = -1; m_lat = -1; a_oe_n = 0; b_oe_n = 0; m_oe_n = 0; bad_misc = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0005; cpu_wdata = 16'h3C3C;
    for (int c = 1; c <= 24; c++) begin
      @(posedge Clk); #1;
      if (a_lat < 0) begin
        if (a_oe) a_oe_n++;
        if (a_we || a_ldr_done || (a_grant != 2'b00 && a_grant != 2'b01)) bad_misc++;
        if (a_cpu_done) begin
          a_lat = c;
          chk("w1 rdata", {a_cpu_rdata, a_ldr_rdata}, {w_rdata, 16'h0000});
          chk("w1 addr", {a_mem_addr, a_mem_wdata}, {16'h0005, 16'h3C3C});
        end
      end
      if (b_lat < 0) begin
        if (b_oe) b_oe_n++;
        if (b_we || b_ldr_done || (b_grant != 2'b00 && b_grant != 2'b01)) bad_misc++;
        if (b_cpu_done) begin
          b_lat = c;
          chk("w15 rdata", {b_cpu_rdata, b_ldr_rdata}, {w_rdata, 16'h0000});
          chk("w15 addr", {b_mem_addr, b_mem_wdata}, {16'h0005, 16'h3C3C});
        end
      end
      if (m_lat < 0) begin
        if (Mem_OE) m_oe_n++;
        if (cpu_done) m_lat = c;
      end
    end
    cpu_req = 1'b0;
    chk("w1 lat", a_lat, 3);
    chk("w1 oe width", a_oe_n, 1);
    chk("w15 lat", b_lat, 17);
    chk("w15 oe width", b_oe_n, 15);
    chk("w2 lat", m_lat, 4);
    chk("w2 oe width", m_oe_n, 2);
    chk("sweep side effects", bad_misc, 0);

    // Random traffic against the reference model
    do_reset();
    for (int i = 0; i < 16; i++) begin
      d = 16'($urandom);
      preload(16'(i), d);
      golden[i] = d;
    end
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge Clk);
      model_step();
      #1;
      model_check();
      if (m_left == 1 && !m_ldr) cpu_req = 1'b0;
      else if (!cpu_req && $urandom_range(0, 2) == 0) begin
        cpu_req = 1'b1; cpu_we = 1'($urandom);
        cpu_addr = 16'($urandom_range(0, 15)); cpu_wdata = 16'($urandom);
      end
      if (m_left == 1 && m_ldr) ldr_req = 1'b0;
      else if (!ldr_req && $urandom_range(0, 2) == 0) begin
        ldr_req = 1'b1; ldr_we = 1'($urandom);
        ldr_addr = 16'($urandom_range(0, 15)); ldr_wdata = 16'($urandom);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, is the number of cycles Mem_OE/Mem_WE are held per access; legal range is 1..15.
REQ-002 Clk  input  1  system clock; all state changes on its rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 cpu_req  input  1  CPU access request, level; held with cpu_we/cpu_addr/cpu_wdata stable until cpu_done.
REQ-005 cpu_we  input  1  1 = write, 0 = read.
REQ-006 cpu_addr  input  16  CPU word address.
REQ-007 cpu_wdata  input  16  CPU write data.
REQ-008 cpu_rdata  output  16  CPU read data, registered.
REQ-009 cpu_done  output  1  one-cycle completion pulse to the CPU.
REQ-010 ldr_req, ldr_we, ldr_addr[15:0], ldr_wdata[15:0]  input  loader port with the same semantics as the CPU port.
REQ-011 ldr_rdata  output  16  and ldr_done  output  1: loader read data and completion pulse.
REQ-012 mem_addr  output  16  SRAM address, registered.
REQ-013 mem_wdata  output  16  SRAM write data, registered.
REQ-014 mem_rdata  input  16  SRAM read data.
REQ-015 Mem_OE  output  1  and Mem_WE  output  1: SRAM output-enable and write-enable, both active-high.
REQ-016 grant  output  2  owner of the current access: 00 none, 01 CPU, 10 loader.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, SETUP, ACCESS and DONE.
REQ-018 IDLE: if any request is high at the clock edge, the FSM SHALL pick a winner, latch its we/addr/wdata into internal registers and mem_addr/mem_wdata, set grant, and go to SETUP; otherwise it stays in IDLE.
REQ-019 Arbitration SHALL be round-robin.
- A single requester always wins.
- When both request, the port not served last wins.
- The last-served register updates only at grant.
REQ-020 SETUP lasts 1 cycle: address is stable and Mem_OE=Mem_WE=0; the wait counter is loaded with WAIT_CYCLES-1; the next state is ACCESS.
REQ-021 ACCESS lasts exactly WAIT_CYCLES cycles.
- A read holds Mem_OE=1; a write holds Mem_WE=1.
- Mem_OE and Mem_WE are never both 1.
- The counter decrements each cycle; at count 0 the next state is DONE.
REQ-022 On the final ACCESS edge of a read, mem_rdata SHALL be registered into the granted port's rdata only; the other port's rdata is unchanged.
REQ-023 DONE lasts 1 cycle.
- The granted port's done is 1 for exactly that cycle; Mem_OE=Mem_WE=0.
- rdata is valid for reads.
- The next state is IDLE, and grant returns to 00 on entering IDLE.
REQ-024 Latency: with the request already high in IDLE at cycle t, done SHALL be high in cycle t+2+WAIT_CYCLES; a back-to-back access occupies at least 3+WAIT_CYCLES cycles.
REQ-025 Requests SHALL be ignored outside IDLE; the unserved port's request remains pending and is served on the next IDLE decision.
REQ-026 A requester SHALL deassert req on the edge following its done; a req still high in IDLE is treated as a new access.
REQ-027 rdata outputs SHALL hold their value until overwritten by a later read for the same port; writes never modify rdata.
REQ-028 A change of request inputs during SETUP, ACCESS or DONE SHALL NOT affect mem_addr, mem_wdata, Mem_OE, Mem_WE or the current grant.

Reset
REQ-029 Reset SHALL force the following at the next edge, from any state including mid-ACCESS:
- state = IDLE, grant = 00;
- Mem_OE = Mem_WE = 0;
- cpu_done = ldr_done = 0;
- mem_addr = mem_wdata = 0;
- cpu_rdata = ldr_rdata = 0;
- last-served = loader, so the CPU wins the first tie.
REQ-030 A transaction interrupted by Reset SHALL NOT produce a done pulse; the requester must re-request.

Verification
REQ-031 CPU read only, WAIT_CYCLES=2, cpu_addr=0x0040, mem_rdata=0xBEEF -> Mem_OE high 2 cycles, cpu_done in cycle t+4, cpu_rdata=0xBEEF, ldr_rdata=0.
REQ-032 Loader write only, ldr_addr=0x1234, ldr_wdata=0x5A5A -> mem_addr=0x1234, mem_wdata=0x5A5A, Mem_WE high 2 cycles, Mem_OE never high, ldr_done one pulse, no cpu_done.
REQ-033 Both requests rise in the same cycle after reset -> CPU granted first (grant=01), loader served next (grant=10), and a further tie is granted to the CPU.
REQ-034 Reset asserted during the second ACCESS cycle of a CPU write -> next edge Mem_WE=0, state IDLE, no cpu_done; a re-issued request then completes normally.
REQ-035 WAIT_CYCLES=1 and WAIT_CYCLES=15 -> Mem_OE width 1 and 15 cycles respectively, done at t+3 and t+17.
REQ-036 cpu_addr changes during ACCESS -> mem_addr unchanged until the next grant.
